// File: rtl/shift_register_pkg.sv
// Shared constants for the serial shift register and its bit counter.
package shift_register_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Counter must represent 0..width inclusive.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/shift_bit_counter.sv
// Remaining-bit down-counter: loads WIDTH, decrements per shift, flags zero.
// Latency: count updates one edge after load/shift; zero is combinational from the count.
module shift_bit_counter
    import shift_register_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(WIDTH);
        end else if (shift && !zero) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/shift_register_8bit.sv
// Parallel-load, LSB-first serial shift register; serial out is reg_data[0] with no extra stage.
// Optional SHIFT_REG_LOAD_GUARD_EN ignores loads while loaded bits remain.
module shift_register_8bit
    import shift_register_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             enable_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             shift_register_out,
    output logic             busy_o
);

    localparam int CNT_W = cnt_width(WIDTH);

    if (WIDTH < 2) begin : g_width_check
        $error("shift_register_8bit: WIDTH must be at least 2");
    end

    logic [WIDTH-1:0] reg_data;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;
    logic             load_acc;
    logic             shift_en;

`ifdef SHIFT_REG_LOAD_GUARD_EN
    // A load while bits are still pending is dropped so the current word finishes.
    assign load_acc = load_i && cnt_zero;
`else
    assign load_acc = load_i;
`endif

    assign shift_en = enable_i && !load_acc && !cnt_zero;

    shift_bit_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .load  (load_acc),
        .shift (shift_en),
        .cnt   (cnt),
        .zero  (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_data <= '0;
        end else if (load_acc) begin
            reg_data <= data_i;
        end else if (shift_en) begin
            reg_data <= {1'b0, reg_data[WIDTH-1:1]};
        end
    end

    assign shift_register_out = reg_data[0];
    assign busy_o             = !cnt_zero;

endmodule

// File: tb/tb_shift_register_8bit.sv
// Directed bench for shift_register_8bit; expectations follow the SHIFT_REG_LOAD_GUARD_EN setting.
module tb_shift_register_8bit;

    logic       clk;
    logic       rst;
    logic       load_i;
    logic       enable_i;
    logic [7:0] data_i;
    logic       shift_register_out;
    logic       busy_o;

    int checks = 0;
    int errors = 0;

    shift_register_8bit #(.WIDTH(8)) dut (
        .clk                (clk),
        .rst                (rst),
        .load_i             (load_i),
        .enable_i           (enable_i),
        .data_i             (data_i),
        .shift_register_out (shift_register_out),
        .busy_o             (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic ld, input logic en, input logic [7:0] d);
        rst      = r;
        load_i   = ld;
        enable_i = en;
        data_i   = d;
    endtask

    initial begin
        logic [7:0] seq_a5;
        logic [7:0] seq_3c;
        seq_a5 = 8'b1010_0101;
        seq_3c = 8'b0011_1100;

        drive(1'b0, 1'b0, 1'b0, 8'h00);

        // Reset wins over load and enable.
        drive(1'b1, 1'b1, 1'b1, 8'hFF);
        tick();
        check("rst_out", shift_register_out, 0);
        check("rst_busy", busy_o, 0);
        check("rst_reg", dut.reg_data, 8'h00);
        check("rst_cnt", dut.cnt, 0);

        // Load A5 on first edge out of reset, then 8 shifts.
        drive(1'b0, 1'b1, 1'b0, 8'hA5);
        tick();
        check("load_reg", dut.reg_data, 8'hA5);
        check("load_cnt", dut.cnt, 8);
        check("load_busy", busy_o, 1);
        drive(1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("full_bit%0d", i), shift_register_out, seq_a5[i]);
            tick();
        end
        check("full_end_out", shift_register_out, 0);
        check("full_end_busy", busy_o, 0);
        check("full_end_reg", dut.reg_data, 8'h00);
        tick();
        check("idle_en_cnt", dut.cnt, 0);
        check("idle_en_out", shift_register_out, 0);

        // Pause: 3 shifts, 4 idle edges, then resume.
        drive(1'b0, 1'b1, 1'b0, 8'hA5);
        tick();
        drive(1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("pause_pre%0d", i), shift_register_out, seq_a5[i]);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("pause_out%0d", i), shift_register_out, 0);
            check($sformatf("pause_reg%0d", i), dut.reg_data, 8'h14);
        end
        check("pause_cnt", dut.cnt, 5);
        drive(1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 4; i < 8; i++) begin
            tick();
            check($sformatf("resume_bit%0d", i), shift_register_out, seq_a5[i]);
        end
        tick();
        check("resume_end_busy", busy_o, 0);

        // Simultaneous load and enable: load wins, no shift that edge.
        drive(1'b0, 1'b1, 1'b1, 8'h3C);
        tick();
        check("simul_reg", dut.reg_data, 8'h3C);
        check("simul_out", shift_register_out, 0);
        check("simul_cnt", dut.cnt, 8);
        drive(1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 1; i < 8; i++) begin
            tick();
            check($sformatf("simul_bit%0d", i), shift_register_out, seq_3c[i]);
        end
        tick();
        check("simul_end_busy", busy_o, 0);

        // Load request mid-shift.
        drive(1'b0, 1'b1, 1'b0, 8'hA5);
        tick();
        drive(1'b0, 1'b0, 1'b1, 8'h00);
        tick();
        tick();
        check("guard_pre_out", shift_register_out, 1);
        check("guard_pre_cnt", dut.cnt, 6);
        drive(1'b0, 1'b1, 1'b1, 8'hFF);
        tick();
`ifdef SHIFT_REG_LOAD_GUARD_EN
        check("guard_cnt", dut.cnt, 5);
        check("guard_reg", dut.reg_data, 8'h14);
        for (int i = 3; i < 8; i++) begin
            check($sformatf("guard_bit%0d", i), shift_register_out, seq_a5[i]);
            tick();
        end
        check("guard_end_busy", busy_o, 0);
`else
        check("noguard_out", shift_register_out, 1);
        check("noguard_cnt", dut.cnt, 8);
        check("noguard_reg", dut.reg_data, 8'hFF);
`endif

        // Reset mid-shift, then a fresh load of 01.
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        drive(1'b0, 1'b1, 1'b0, 8'hA5);
        tick();
        drive(1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 4; i++) tick();
        check("mid_reg", dut.reg_data, 8'h0A);
        check("mid_busy_pre", busy_o, 1);
        drive(1'b1, 1'b1, 1'b1, 8'hFF);
        tick();
        check("mid_rst_reg", dut.reg_data, 8'h00);
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_out", shift_register_out, 0);
        drive(1'b0, 1'b1, 1'b0, 8'h01);
        tick();
        check("post_rst_out1", shift_register_out, 1);
        check("post_rst_busy", busy_o, 1);
        drive(1'b0, 1'b0, 1'b1, 8'h00);
        tick();
        check("post_rst_out0", shift_register_out, 0);
        check("post_rst_cnt", dut.cnt, 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
